glitch_sweep_sequencer: RTL and testbench

Automatic sweep engine between the UART command processor and the glitch datapath (resetter, offset counter, duration counter). Given a start offset, end offset, step and fixed duration, it fires one glitch attempt per offset value: it pulses `target_reset`, presents `offset`/`duration` to the counters, waits for the datapath's attempt-complete pulse (or a timeout), lets the target settle, then advances. The host can then run a full offset scan with a single command instead of one command per attempt.

---
 rtl/glitch_pkg.sv | 22 ++
 rtl/cycle_timer.sv | 28 ++
 rtl/glitch_sweep_sequencer.sv | 149 ++++++++++++++
 tb/tb_glitch_sweep_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/glitch_pkg.sv
// Shared types and sizing constants for the glitch sweep logic.
package glitch_pkg;

  localparam int GLITCH_WIDTH  = 32;
  localparam int ATTEMPT_CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRE,
    S_WAIT,
    S_SETTLE,
    S_DONE
  } sweep_state_t;

  // Bits needed for a down-counter that must hold the larger of two cycle counts.
  function automatic int timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; expired_o is high in the last cycle of a loaded interval.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         expired_o
);

  logic [W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= value_i;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  // A load of N yields N cycles of counting with expiry flagged on the Nth.
  assign expired_o = (count_q == W'(1));

endmodule

// File: rtl/glitch_sweep_sequencer.sv
// Offset sweep engine: fires one glitch attempt per offset, waits for completion or timeout, settles, advances.
module glitch_sweep_sequencer
  import glitch_pkg::*;
#(
  parameter int          WIDTH          = GLITCH_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned SETTLE_CYCLES  = 10_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         cfg_offset_start,
  input  logic [WIDTH-1:0]         cfg_offset_end,
  input  logic [WIDTH-1:0]         cfg_offset_step,
  input  logic [WIDTH-1:0]         cfg_duration,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     attempt_done,
  output logic                     target_reset,
  output logic [WIDTH-1:0]         offset,
  output logic [WIDTH-1:0]         duration,
  output logic                     busy,
  output logic                     sweep_done,
  output logic [ATTEMPT_CNT_W-1:0] attempt_count,
  output logic                     timeout_err
);

  localparam int                 TIMER_W      = timer_width(TIMEOUT_CYCLES, SETTLE_CYCLES);
  localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] SETTLE_LOAD  = TIMER_W'(SETTLE_CYCLES);

  sweep_state_t             state_q;
  logic [WIDTH-1:0]         offset_q;
  logic [WIDTH-1:0]         duration_q;
  logic [WIDTH-1:0]         end_q;
  logic [WIDTH-1:0]         step_q;
  logic [ATTEMPT_CNT_W-1:0] count_q;
  logic                     target_reset_q;
  logic                     busy_q;
  logic                     sweep_done_q;
  logic                     timeout_err_q;

  logic [WIDTH:0]           next_offset_d;
  logic                     last_attempt;
  logic                     timer_load;
  logic [TIMER_W-1:0]       timer_value;
  logic                     timer_expired;

  // Extra top bit catches wrap-around so the sweep never jumps back to a low offset.
  assign next_offset_d = {1'b0, offset_q} + {1'b0, step_q};
  assign last_attempt  = (step_q == '0) || next_offset_d[WIDTH] ||
                         (next_offset_d[WIDTH-1:0] > end_q) || (offset_q >= end_q);

  // The single timer is armed for the timeout on FIRE and for the settle gap on leaving WAIT.
  assign timer_load  = (state_q == S_FIRE) ||
                       ((state_q == S_WAIT) && (attempt_done || timer_expired));
  assign timer_value = (state_q == S_FIRE) ? TIMEOUT_LOAD : SETTLE_LOAD;

  cycle_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (timer_load),
    .value_i   (timer_value),
    .expired_o (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      offset_q       <= '0;
      duration_q     <= '0;
      end_q          <= '0;
      step_q         <= '0;
      count_q        <= '0;
      target_reset_q <= 1'b0;
      busy_q         <= 1'b0;
      sweep_done_q   <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else if (abort) begin
      // Abort freezes offset/duration/count; only the control flags drop.
      state_q        <= S_IDLE;
      target_reset_q <= 1'b0;
      busy_q         <= 1'b0;
      sweep_done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            offset_q       <= cfg_offset_start;
            duration_q     <= cfg_duration;
            end_q          <= cfg_offset_end;
            step_q         <= cfg_offset_step;
            count_q        <= '0;
            timeout_err_q  <= 1'b0;
            target_reset_q <= 1'b1;
            busy_q         <= 1'b1;
            state_q        <= S_FIRE;
          end
        end
        S_FIRE: begin
          target_reset_q <= 1'b0;
          if (count_q != '1) count_q <= count_q + ATTEMPT_CNT_W'(1);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (attempt_done) begin
            state_q <= S_SETTLE;
          end else if (timer_expired) begin
            timeout_err_q <= 1'b1;
            state_q       <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (timer_expired) begin
            if (last_attempt) begin
              sweep_done_q <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              offset_q       <= next_offset_d[WIDTH-1:0];
              target_reset_q <= 1'b1;
              state_q        <= S_FIRE;
            end
          end
        end
        S_DONE: begin
          sweep_done_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: begin
          target_reset_q <= 1'b0;
          busy_q         <= 1'b0;
          sweep_done_q   <= 1'b0;
          state_q        <= S_IDLE;
        end
      endcase
    end
  end

  assign target_reset  = target_reset_q;
  assign offset        = offset_q;
  assign duration      = duration_q;
  assign busy          = busy_q;
  assign sweep_done    = sweep_done_q;
  assign attempt_count = count_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_glitch_sweep_sequencer.sv
// Directed bench for glitch_sweep_sequencer with a scoreboard of expected attempt offsets.
module tb_glitch_sweep_sequencer;

  localparam int T_CYC = 50;
  localparam int S_CYC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cfg_offset_start = '0;
  logic [31:0] cfg_offset_end   = '0;
  logic [31:0] cfg_offset_step  = '0;
  logic [31:0] cfg_duration     = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        attempt_done = 1'b0;
  logic        target_reset;
  logic [31:0] offset;
  logic [31:0] duration;
  logic        busy;
  logic        sweep_done;
  logic [15:0] attempt_count;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulse_cnt = 0;
  int done_cnt  = 0;
  int done_t    = 0;
  int pulse_t[$];
  logic [31:0] exp_q[$];

  glitch_sweep_sequencer #(
    .WIDTH          (32),
    .TIMEOUT_CYCLES (T_CYC),
    .SETTLE_CYCLES  (S_CYC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_offset_start (cfg_offset_start),
    .cfg_offset_end   (cfg_offset_end),
    .cfg_offset_step  (cfg_offset_step),
    .cfg_duration     (cfg_duration),
    .start            (start),
    .abort            (abort),
    .attempt_done     (attempt_done),
    .target_reset     (target_reset),
    .offset           (offset),
    .duration         (duration),
    .busy             (busy),
    .sweep_done       (sweep_done),
    .attempt_count    (attempt_count),
    .timeout_err      (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every target_reset pulse must match the next queued offset.
  always @(negedge clk) begin
    cyc++;
    if (target_reset) begin
      pulse_cnt++;
      pulse_t.push_back(cyc);
      check("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("pulse_offset", 64'(offset), 64'(exp_q.pop_front()));
    end
    if (sweep_done) begin
      done_cnt++;
      done_t = cyc;
    end
  end

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Returns at the negedge of the FIRE cycle that follows the start pulse.
  task automatic start_sweep(input logic [31:0] s, input logic [31:0] e,
                             input logic [31:0] st, input logic [31:0] d);
    cfg_offset_start = s;
    cfg_offset_end   = e;
    cfg_offset_step  = st;
    cfg_duration     = d;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Answers each target_reset with attempt_done after 'delay' cycles until the sweep ends.
  task automatic run_sweep(input bit respond, input int delay, input int budget);
    int  cd;
    bit  seen_done;
    bit  finished;
    cd        = delay;
    seen_done = 1'b0;
    finished  = 1'b0;
    for (int n = 0; n < budget && !finished; n++) begin
      @(negedge clk);
      attempt_done = 1'b0;
      if (target_reset) begin
        cd = delay;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0 && respond) attempt_done = 1'b1;
      end
      if (sweep_done) seen_done = 1'b1;
      if (seen_done && !busy) finished = 1'b1;
    end
    attempt_done = 1'b0;
    check("sweep_finished_in_budget", 64'(finished), 64'd1);
  endtask

  task automatic single_attempt(input string tag, input logic [31:0] s, input logic [31:0] e,
                                input logic [31:0] st);
    int p0, d0;
    p0 = pulse_cnt;
    d0 = done_cnt;
    exp_q.push_back(s);
    start_sweep(s, e, st, 32'h9);
    run_sweep(1'b1, 3, 400);
    check({tag, "_pulses"}, 64'(pulse_cnt - p0), 64'd1);
    check({tag, "_dones"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_count"}, 64'(attempt_count), 64'd1);
    check({tag, "_offset_hold"}, 64'(offset), 64'(s));
    check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int p0, d0;

    // Reset state
    wait_neg(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_target_reset", 64'(target_reset), 64'd0);
    check("rst_offset", 64'(offset), 64'd0);
    check("rst_duration", 64'(duration), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sweep_done", 64'(sweep_done), 64'd0);
    check("rst_attempt_count", 64'(attempt_count), 64'd0);
    check("rst_timeout_err", 64'(timeout_err), 64'd0);

    // Four-step sweep with prompt completion
    p0 = pulse_cnt;
    d0 = done_cnt;
    pulse_t.delete();
    exp_q.push_back(32'h100); exp_q.push_back(32'h110);
    exp_q.push_back(32'h120); exp_q.push_back(32'h130);
    start_sweep(32'h100, 32'h130, 32'h10, 32'h7);
    check("t1_fire_pulse", 64'(target_reset), 64'd1);
    check("t1_fire_busy", 64'(busy), 64'd1);
    check("t1_fire_duration", 64'(duration), 64'h7);
    run_sweep(1'b1, 2, 1000);
    check("t1_pulses", 64'(pulse_cnt - p0), 64'd4);
    check("t1_dones", 64'(done_cnt - d0), 64'd1);
    check("t1_count", 64'(attempt_count), 64'd4);
    check("t1_offset_hold", 64'(offset), 64'h130);
    check("t1_duration_hold", 64'(duration), 64'h7);
    check("t1_timeout_err", 64'(timeout_err), 64'd0);
    check("t1_sb_empty", 64'(exp_q.size()), 64'd0);
    // FIRE + 2 WAIT + SETTLE_CYCLES, and DONE the cycle after the last SETTLE cycle
    if (pulse_t.size() == 4) begin
      check("t1_period", 64'(pulse_t[1] - pulse_t[0]), 64'(3 + S_CYC));
      check("t1_done_latency", 64'(done_t - pulse_t[3]), 64'(3 + S_CYC));
    end

    // Single-attempt boundaries: zero step, start above end, carry out of the adder
    single_attempt("step0", 32'h50, 32'h60, 32'h0);
    single_attempt("start_gt_end", 32'h80, 32'h10, 32'h10);
    single_attempt("carry", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20);

    // Timeouts: no answer in time; a late attempt_done lands in SETTLE and is ignored
    p0 = pulse_cnt;
    pulse_t.delete();
    exp_q.push_back(32'h10); exp_q.push_back(32'h20);
    start_sweep(32'h10, 32'h20, 32'h10, 32'h3);
    run_sweep(1'b1, T_CYC + 2, 1000);
    check("to_pulses", 64'(pulse_cnt - p0), 64'd2);
    check("to_timeout_err", 64'(timeout_err), 64'd1);
    check("to_count", 64'(attempt_count), 64'd2);
    if (pulse_t.size() == 2)
      check("to_period", 64'(pulse_t[1] - pulse_t[0]), 64'(1 + T_CYC + S_CYC));

    // attempt_done in the very cycle the timer expires counts as done
    pulse_t.delete();
    exp_q.push_back(32'h40); exp_q.push_back(32'h48);
    start_sweep(32'h40, 32'h48, 32'h8, 32'h3);
    check("edge_err_cleared_on_start", 64'(timeout_err), 64'd0);
    run_sweep(1'b1, T_CYC, 1000);
    check("edge_timeout_err", 64'(timeout_err), 64'd0);
    if (pulse_t.size() == 2)
      check("edge_period", 64'(pulse_t[1] - pulse_t[0]), 64'(1 + T_CYC + S_CYC));

    // Abort during the second WAIT; a start with new cfg mid-sweep must be ignored
    p0 = pulse_cnt;
    d0 = done_cnt;
    exp_q.push_back(32'h200); exp_q.push_back(32'h210);
    start_sweep(32'h200, 32'h230, 32'h10, 32'h5);
    wait_neg(10);
    cfg_offset_start = 32'hDEAD_0000;
    cfg_offset_step  = 32'h1;
    cfg_duration     = 32'h77;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_neg(T_CYC + S_CYC + 10 - 11);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_busy", 64'(busy), 64'd0);
    check("ab_count", 64'(attempt_count), 64'd2);
    check("ab_offset_hold", 64'(offset), 64'h210);
    check("ab_duration_hold", 64'(duration), 64'h5);
    wait_neg(120);
    check("ab_pulses", 64'(pulse_cnt - p0), 64'd2);
    check("ab_no_done", 64'(done_cnt - d0), 64'd0);
    check("ab_sb_empty", 64'(exp_q.size()), 64'd0);

    // Reset mid-SETTLE
    p0 = pulse_cnt;
    exp_q.push_back(32'h300);
    start_sweep(32'h300, 32'h340, 32'h10, 32'h6);
    @(negedge clk);
    @(negedge clk);
    attempt_done = 1'b1;
    @(negedge clk);
    attempt_done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_target_reset", 64'(target_reset), 64'd0);
    check("mr_offset", 64'(offset), 64'd0);
    check("mr_duration", 64'(duration), 64'd0);
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_count", 64'(attempt_count), 64'd0);
    check("mr_timeout_err", 64'(timeout_err), 64'd0);
    wait_neg(30);
    check("mr_no_pulses", 64'(pulse_cnt - p0), 64'd1);

    // start and abort together: abort wins
    p0 = pulse_cnt;
    cfg_offset_start = 32'h500;
    cfg_offset_end   = 32'h510;
    cfg_offset_step  = 32'h10;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", 64'(busy), 64'd0);
    check("sa_offset", 64'(offset), 64'd0);
    wait_neg(20);
    check("sa_no_pulses", 64'(pulse_cnt - p0), 64'd0);
    check("sa_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
